// File: rtl/stepper_pkg.sv
// stepper_pkg: shared state type, coil phase table and phase-index stepping helper
package stepper_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Entry [0] is the last element of the concatenation: 1000, 1100, 0100, ... 1001
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    // Half-step moves one entry. Full-step always lands on an odd (two-coil) entry:
    // an odd index moves two entries, an even index moves to its odd neighbour.
    function automatic logic [2:0] next_index(input logic [2:0] idx, input logic dir, input logic half);
        logic [1:0] hi_up;
        logic [1:0] hi_dn;
        hi_up = idx[0] ? idx[2:1] + 2'd1 : idx[2:1];
        hi_dn = idx[2:1] - 2'd1;
        if (half)
            return dir ? idx + 3'd1 : idx - 3'd1;
        return dir ? {hi_up, 1'b1} : {hi_dn, 1'b1};
    endfunction

endpackage

// File: rtl/stepper_ctrl_if.sv
// stepper_ctrl_if: move-command handshake between motion control and the sequencer
interface stepper_ctrl_if #(
    parameter int STEP_W = 16,
    parameter int DIV_W  = 20
);
    logic              valid;
    logic              ready;
    logic [STEP_W-1:0] steps;
    logic              dir;
    logic              half;
    logic [DIV_W-1:0]  period;

    modport master (output valid, steps, dir, half, period, input ready);
    modport slave  (input valid, steps, dir, half, period, output ready);
endinterface

// File: rtl/step_rate_gen.sv
// step_rate_gen: divider that ticks once every period+1 clocks while not cleared
module step_rate_gen #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Tick on the terminal count and wrap to zero; held at zero while cleared
    always_comb begin
        tick  = !clear && cnt_q == period;
        cnt_d = (clear || tick) ? '0 : cnt_q + DIV_W'(1);
    end

    // Divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/stepper_ctrl.sv
// stepper_ctrl: command-driven 4-coil unipolar stepper sequencer with position tracking
module stepper_ctrl
    import stepper_pkg::*;
#(
    parameter int STEP_W = 16,
    parameter int DIV_W  = 20,
    parameter int POS_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    stepper_ctrl_if.slave    cmd,
    input  logic             stop,
    input  logic             hold_en,
    output logic [3:0]       coils,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] position
);
    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [3:0]        coils_q, coils_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [DIV_W-1:0]  period_q, period_d;
    logic              dir_q, dir_d;
    logic              half_q, half_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              zero_q, zero_d;
    logic              tick;
    logic [POS_W-1:0]  delta;

    step_rate_gen #(.DIV_W(DIV_W)) u_rate (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != RUN),
        .period (period_q),
        .tick   (tick)
    );

    assign cmd.ready = state_q == IDLE;
    assign busy      = state_q == RUN;
    assign coils     = coils_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign position  = pos_q;
    assign delta     = half_q ? POS_W'(1) : POS_W'(2);

    // Command acceptance, step sequencing, abort and registered coil drive
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        steps_d   = steps_q;
        period_d  = period_q;
        dir_d     = dir_q;
        half_d    = half_q;
        done_d    = zero_q;
        aborted_d = 1'b0;
        zero_d    = 1'b0;
        if (state_q == IDLE) begin
            if (cmd.valid) begin
                steps_d  = cmd.steps;
                period_d = cmd.period;
                dir_d    = cmd.dir;
                half_d   = cmd.half;
                zero_d   = cmd.steps == '0;
                state_d  = cmd.steps == '0 ? IDLE : RUN;
            end
        end else if (stop) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end else if (tick) begin
            idx_d   = next_index(idx_q, dir_q, half_q);
            pos_d   = dir_q ? pos_q + delta : pos_q - delta;
            steps_d = steps_q - STEP_W'(1);
            if (steps_q == STEP_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        coils_d = (state_d == RUN || hold_en) ? PHASE_TABLE[idx_d] : 4'b0000;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            coils_q   <= '0;
            pos_q     <= '0;
            steps_q   <= '0;
            period_q  <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            coils_q   <= coils_d;
            pos_q     <= pos_d;
            steps_q   <= steps_d;
            period_q  <= period_d;
            dir_q     <= dir_d;
            half_q    <= half_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            zero_q    <= zero_d;
        end
    end
endmodule

// File: tb/tb_stepper_ctrl.sv
// tb_stepper_ctrl: directed vector table plus hand sequences for stepper_ctrl
module tb_stepper_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic        hold_en = 1'b0;
    logic [3:0]  coils;
    logic        busy, done, aborted;
    logic [23:0] position;
    int          checks = 0;
    int          errors = 0;

    stepper_ctrl_if #(.STEP_W(16), .DIV_W(20)) cif ();

    stepper_ctrl #(.STEP_W(16), .DIV_W(20), .POS_W(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cif.slave),
        .stop     (stop),
        .hold_en  (hold_en),
        .coils    (coils),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .position (position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] steps;
        logic        dir;
        logic        half;
        logic [19:0] period;
        logic [3:0]  coils;
        logic [23:0] pos;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic send(input logic [15:0] s, input logic d, input logic h, input logic [19:0] p);
        cif.valid  = 1'b1;
        cif.steps  = s;
        cif.dir    = d;
        cif.half   = h;
        cif.period = p;
        step();
        cif.valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_c[4];
        int n;
        vecs[0] = '{16'd3, 1'b1, 1'b0, 20'd0, 4'b0011, 24'd6, 3};
        vecs[1] = '{16'd2, 1'b0, 1'b1, 20'd0, 4'b0001, 24'hFFFFFE, 2};
        vecs[2] = '{16'd8, 1'b1, 1'b1, 20'd2, 4'b1000, 24'd8, 24};
        vecs[3] = '{16'd5, 1'b0, 1'b0, 20'd0, 4'b1001, 24'hFFFFF6, 5};
        vecs[4] = '{16'd1, 1'b1, 1'b0, 20'd0, 4'b1100, 24'd2, 1};
        vecs[5] = '{16'd9, 1'b1, 1'b1, 20'd1, 4'b1100, 24'd9, 18};
        vecs[6] = '{16'd4, 1'b0, 1'b1, 20'd0, 4'b0010, 24'hFFFFFC, 4};
        exp_c = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};
        cif.valid = 1'b0; cif.steps = '0; cif.dir = 1'b0; cif.half = 1'b0; cif.period = '0;

        #2;
        chk("reset_ready", cif.ready, 1);
        chk("reset_coils", coils, 0);
        step();
        reset = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_pos", position, 0);

        hold_en = 1'b1;
        step();
        chk("hold_idle_coils", coils, 4'b1000);
        send(16'd4, 1'b1, 1'b1, 20'd2);
        chk("run_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            step();
            chk("hs_before_tick", coils, k == 0 ? 4'b1000 : exp_c[k-1]);
            step();
            chk("hs_step_coils", coils, exp_c[k]);
        end
        chk("hs_done", done, 1);
        chk("hs_aborted", aborted, 0);
        chk("hs_busy", busy, 0);
        chk("hs_pos", position, 4);
        step();
        chk("hs_done_pulse", done, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            hold_en = 1'b1;
            send(vecs[i].steps, vecs[i].dir, vecs[i].half, vecs[i].period);
            wait_done(1000, n);
            chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
            chk($sformatf("v%0d_coils", i), coils, vecs[i].coils);
            chk($sformatf("v%0d_pos", i), position, vecs[i].pos);
            chk($sformatf("v%0d_aborted", i), aborted, 0);
            chk($sformatf("v%0d_busy", i), busy, 0);
        end

        for (int h = 0; h < 2; h++) begin
            do_reset();
            hold_en = h[0];
            send(16'd100, 1'b1, 1'b1, 20'd9);
            repeat (20) step();
            chk("ab_pos2", position, 2);
            repeat (9) step();
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk("ab_done", done, 1);
            chk("ab_aborted", aborted, 1);
            chk("ab_busy", busy, 0);
            chk("ab_pos", position, 2);
            chk("ab_coils", coils, h ? 4'b0100 : 4'b0000);
            step();
            chk("ab_done_clear", done, 0);
        end

        do_reset();
        hold_en = 1'b0;
        stop = 1'b1;
        step();
        chk("stop_idle_done", done, 0);
        send(16'd0, 1'b1, 1'b1, 20'd0);
        stop = 1'b0;
        chk("zero_no_busy", busy, 0);
        chk("zero_no_done_yet", done, 0);
        step();
        chk("zero_done", done, 1);
        chk("zero_aborted", aborted, 0);
        chk("zero_busy", busy, 0);
        chk("zero_coils", coils, 0);
        chk("zero_pos", position, 0);
        step();
        chk("zero_done_pulse", done, 0);

        stop = 1'b1;
        send(16'd2, 1'b1, 1'b1, 20'd0);
        stop = 1'b0;
        wait_done(100, n);
        chk("stopcmd_lat", n, 2);
        chk("stopcmd_aborted", aborted, 0);
        chk("stopcmd_pos", position, 2);

        do_reset();
        send(16'd5, 1'b1, 1'b1, 20'd3);
        cif.valid = 1'b1; cif.steps = 16'd50; cif.period = 20'd0;
        step();
        chk("busy_ready", cif.ready, 0);
        step();
        chk("busy_run", busy, 1);
        cif.valid = 1'b0;
        wait_done(200, n);
        chk("busy_latency", n + 2, 20);
        chk("busy_pos", position, 5);
        step();
        chk("busy_not_accepted", busy, 0);

        do_reset();
        hold_en = 1'b1;
        send(16'd10, 1'b1, 1'b1, 20'd0);
        repeat (3) step();
        chk("ar_pre_pos", position, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_coils", coils, 0);
        chk("ar_pos", position, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", cif.ready, 1);
        hold_en = 1'b0;
        step();
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
